// File: rtl/dma_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// dma_pingpong_ctrl
//
// Purpose:
//   Sequencer for a DMA double buffer. There are two DEPTH-byte buffers. One
//   buffer is filled from the source side while the other is drained to the
//   destination side. The block handles:
//     - transfer direction (CPU->MEM or MEM->CPU)
//     - 8-bit and 4-bit (nibble) beats
//     - transfer length
//     - ping-pong swapping between the two buffers
//   It drives the buffer RAM strobes and both side handshakes. The buffer RAM
//   itself (combinational read) and the data muxing live outside this block.
//
// Parameters:
//   DEPTH  bytes per buffer (power of two)
//   AW     buffer address width, clog2(DEPTH)
//   LEN_W  width of the transfer length in bytes
//
// Ports:
//   clk        in   1      clock
//   resetn     in   1      synchronous, active-low reset
//   start      in   1      start pulse; sampled only in IDLE
//   dir        in   1      1 = CPU->MEM (src 8b, dst 4b), 0 = MEM->CPU (src 4b, dst 8b)
//   len        in   LEN_W  transfer length in bytes; latched at start
//   busy       out  1      transfer in progress
//   done       out  1      one-cycle completion pulse
//   src_valid  in   1      source beat valid
//   src_ready  out  1      controller accepts a source beat
//   dst_ready  in   1      destination accepts a beat
//   dst_valid  out  1      destination beat valid
//   wr_en      out  1      buffer write strobe
//   wr_buf     out  1      buffer being filled
//   wr_addr    out  AW     byte address in the fill buffer
//   wr_nib     out  2      byte lanes written (11 full, 01 low, 10 high)
//   rd_en      out  1      buffer read strobe
//   rd_buf     out  1      buffer being drained
//   rd_addr    out  AW     byte address in the drain buffer
//   rd_nib     out  1      nibble select on a 4-bit destination
// ---------------------------------------------------------------------------
module dma_pingpong_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             dir,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic             dst_ready,
    output logic             dst_valid,
    output logic             wr_en,
    output logic             wr_buf,
    output logic [AW-1:0]    wr_addr,
    output logic [1:0]       wr_nib,
    output logic             rd_en,
    output logic             rd_buf,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_nib
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state;
    logic                 dir_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     fill_left;
    logic [LEN_W-1:0]     drained;
    logic                 wr_ph;
    logic                 rd_ph;
    logic [1:0]           full;
    logic [1:0][AW:0]     cnt;

    logic                 src_is_nib;
    logic                 dst_is_nib;
    logic                 wr_byte_done;
    logic                 rd_byte_done;
    logic                 wr_last;
    logic                 rd_last;
    logic [AW:0]          rd_cnt_m1;
    logic                 xfer_end;

    // CPU->MEM: 8-bit source, 4-bit destination.
    // MEM->CPU: 4-bit source, 8-bit destination.
    assign src_is_nib = ~dir_q;
    assign dst_is_nib = dir_q;

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // The fill side stalls while its target buffer still holds undrained
    // bytes, and once every byte of the transfer has been accepted.
    assign src_ready = (state == ST_RUN) && !full[wr_buf] && (fill_left != '0);
    assign dst_valid = (state == ST_RUN) && full[rd_buf];

    assign wr_en = src_valid & src_ready;
    assign rd_en = dst_valid & dst_ready;

    // Lane select is held at zero whenever no beat can be accepted, so
    // that an idle controller presents all-zero strobes.
    always_comb begin
        wr_nib = 2'b00;
        if (src_ready) begin
            if (!src_is_nib) begin
                wr_nib = 2'b11;
            end else if (wr_ph) begin
                wr_nib = 2'b10;
            end else begin
                wr_nib = 2'b01;
            end
        end
    end

    assign rd_nib = dst_is_nib & rd_ph;

    // A byte is complete on a full-width beat, or on the second
    // (high-nibble) beat of a nibble-wide side.
    assign wr_byte_done = wr_en & (~src_is_nib | wr_ph);
    assign rd_byte_done = rd_en & (~dst_is_nib | rd_ph);

    // A fill buffer closes when it reaches its last address or when the
    // final byte of the transfer arrives (partial last buffer).
    assign wr_last   = (wr_addr == AW'(DEPTH - 1)) || (fill_left == LEN_W'(1));
    assign rd_cnt_m1 = cnt[rd_buf] - (AW + 1)'(1);
    assign rd_last   = ({1'b0, rd_addr} == rd_cnt_m1);
    assign xfer_end  = rd_byte_done && ((drained + LEN_W'(1)) == len_q);

    // Main sequencer. Fill and drain bookkeeping run in parallel while in
    // RUN. Setting full[wr_buf] and clearing full[rd_buf] in the same cycle
    // never collide: the fill side only writes into an empty buffer and the
    // drain side only reads from a full one, so the indices always differ.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            dir_q     <= 1'b0;
            len_q     <= '0;
            fill_left <= '0;
            drained   <= '0;
            wr_buf    <= 1'b0;
            wr_addr   <= '0;
            wr_ph     <= 1'b0;
            rd_buf    <= 1'b0;
            rd_addr   <= '0;
            rd_ph     <= 1'b0;
            full      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_q     <= dir;
                        len_q     <= len;
                        fill_left <= len;
                        drained   <= '0;
                        if (len == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (wr_en) begin
                        if (!wr_byte_done) begin
                            wr_ph <= 1'b1;
                        end else begin
                            wr_ph     <= 1'b0;
                            fill_left <= fill_left - LEN_W'(1);
                            if (wr_last) begin
                                full[wr_buf] <= 1'b1;
                                cnt[wr_buf]  <= {1'b0, wr_addr} + (AW + 1)'(1);
                                wr_buf       <= ~wr_buf;
                                wr_addr      <= '0;
                            end else begin
                                wr_addr <= wr_addr + AW'(1);
                            end
                        end
                    end

                    if (rd_en) begin
                        if (!rd_byte_done) begin
                            rd_ph <= 1'b1;
                        end else begin
                            rd_ph   <= 1'b0;
                            drained <= drained + LEN_W'(1);
                            if (rd_last) begin
                                full[rd_buf] <= 1'b0;
                                rd_buf       <= ~rd_buf;
                                rd_addr      <= '0;
                            end else begin
                                rd_addr <= rd_addr + AW'(1);
                            end
                        end
                    end

                    if (xfer_end) begin
                        state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // Return every pointer to its reset position, so that
                    // the next transfer always starts from buffer 0.
                    state     <= ST_IDLE;
                    fill_left <= '0;
                    drained   <= '0;
                    wr_buf    <= 1'b0;
                    wr_addr   <= '0;
                    wr_ph     <= 1'b0;
                    rd_buf    <= 1'b0;
                    rd_addr   <= '0;
                    rd_ph     <= 1'b0;
                    full      <= '0;
                    cnt       <= '0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_pingpong_ctrl
//
// Purpose:
//   Self-checking bench for dma_pingpong_ctrl. The reference model tracks
//   only the following values:
//     - how many bytes have been accepted and drained
//     - the nibble phase on each side
//   From these it derives buffer, address and flow-control expectations,
//   using plain chunk arithmetic: byte i lives in chunk i/DEPTH, in buffer
//   (i/DEPTH)%2, at address i%DEPTH.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dma_pingpong_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int LEN_W = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             dir;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             src_valid;
    logic             src_ready;
    logic             dst_ready;
    logic             dst_valid;
    logic             wr_en;
    logic             wr_buf;
    logic [AW-1:0]    wr_addr;
    logic [1:0]       wr_nib;
    logic             rd_en;
    logic             rd_buf;
    logic [AW-1:0]    rd_addr;
    logic             rd_nib;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    // m_phase: 0 = idle, 1 = running, 2 = completion cycle.
    int m_phase;
    int m_dir;
    int m_len;
    int m_wb;
    int m_wph;
    int m_rb;
    int m_rph;

    dma_pingpong_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .dir       (dir),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .dst_ready (dst_ready),
        .dst_valid (dst_valid),
        .wr_en     (wr_en),
        .wr_buf    (wr_buf),
        .wr_addr   (wr_addr),
        .wr_nib    (wr_nib),
        .rd_en     (rd_en),
        .rd_buf    (rd_buf),
        .rd_addr   (rd_addr),
        .rd_nib    (rd_nib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. The pass count it steps is the one the
    // summary line reports.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Number of fully formed chunks once b bytes have passed a side.
    function automatic int chunks_done(input int b);
        if (b >= m_len) begin
            return (m_len + DEPTH - 1) / DEPTH;
        end
        return b / DEPTH;
    endfunction

    task automatic modelReset();
        m_phase = 0;
        m_dir   = 0;
        m_len   = 0;
        m_wb    = 0;
        m_wph   = 0;
        m_rb    = 0;
        m_rph   = 0;
    endtask

    // One clock cycle:
    //   1. drive the inputs on the falling edge;
    //   2. compare the DUT against the model;
    //   3. advance the model as the coming rising edge will.
    task automatic applyStimulus(input logic rst_n, input logic st, input logic d,
                                 input int l, input logic sv, input logic dr);
        int  cw;
        int  cd;
        bit  run;
        bit  exp_sr;
        bit  exp_dv;
        bit  wbeat;
        bit  rbeat;
        @(negedge clk);
        resetn    = rst_n;
        start     = st;
        dir       = d;
        len       = l[LEN_W-1:0];
        src_valid = sv;
        dst_ready = dr;
        #1;
        cw     = chunks_done(m_wb);
        cd     = chunks_done(m_rb);
        run    = (m_phase == 1);
        exp_sr = run && (m_wb < m_len) && ((cw - cd) < 2);
        exp_dv = run && (cd < cw);

        checkOutput("busy", int'(busy), int'(run));
        checkOutput("done", int'(done), int'(m_phase == 2));
        checkOutput("src_ready", int'(src_ready), int'(exp_sr));
        checkOutput("dst_valid", int'(dst_valid), int'(exp_dv));
        checkOutput("wr_en", int'(wr_en), int'(sv && exp_sr));
        checkOutput("rd_en", int'(rd_en), int'(dr && exp_dv));

        if (exp_sr) begin
            checkOutput("wr_buf", int'(wr_buf), (m_wb / DEPTH) % 2);
            checkOutput("wr_addr", int'(wr_addr), m_wb % DEPTH);
            checkOutput("wr_nib", int'(wr_nib), (m_dir != 0) ? 3 : ((m_wph != 0) ? 2 : 1));
        end
        if (exp_dv) begin
            checkOutput("rd_buf", int'(rd_buf), (m_rb / DEPTH) % 2);
            checkOutput("rd_addr", int'(rd_addr), m_rb % DEPTH);
            checkOutput("rd_nib", int'(rd_nib), (m_dir != 0) ? m_rph : 0);
        end
        if (m_phase == 0) begin
            checkOutput("idle_wr_buf", int'(wr_buf), 0);
            checkOutput("idle_rd_buf", int'(rd_buf), 0);
            checkOutput("idle_wr_addr", int'(wr_addr), 0);
            checkOutput("idle_rd_addr", int'(rd_addr), 0);
            checkOutput("idle_wr_nib", int'(wr_nib), 0);
            checkOutput("idle_rd_nib", int'(rd_nib), 0);
        end

        wbeat = sv && exp_sr;
        rbeat = dr && exp_dv;
        case (m_phase)
            0: begin
                if (st) begin
                    if (l == 0) begin
                        m_phase = 2;
                    end else begin
                        m_phase = 1;
                        m_dir   = int'(d);
                        m_len   = l;
                        m_wb    = 0;
                        m_wph   = 0;
                        m_rb    = 0;
                        m_rph   = 0;
                    end
                end
            end
            1: begin
                if (wbeat) begin
                    if (m_dir == 0 && m_wph == 0) begin
                        m_wph = 1;
                    end else begin
                        m_wph = 0;
                        m_wb++;
                    end
                end
                if (rbeat) begin
                    if (m_dir != 0 && m_rph == 0) begin
                        m_rph = 1;
                    end else begin
                        m_rph = 0;
                        m_rb++;
                        if (m_rb == m_len) begin
                            m_phase = 2;
                        end
                    end
                end
            end
            default: begin
                m_phase = 0;
            end
        endcase
        if (!rst_n) begin
            modelReset();
        end
    endtask

    // Runs one transfer from start to the return to idle.
    // Handshake activity is randomized with the given percentages, the
    // destination is held off for 'hold' cycles, and spurious start pulses
    // are injected while busy when requested.
    task automatic runTransfer(input logic d, input int l, input int src_pct,
                               input int dst_pct, input int hold, input bit busy_start);
        int  cyc;
        bit  sv;
        bit  dr;
        bit  st;
        applyStimulus(1'b1, 1'b1, d, l, 1'b0, 1'b0);
        cyc = 0;
        while (m_phase != 0 && cyc < 3000) begin
            sv = ($urandom_range(0, 99) < src_pct);
            dr = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < dst_pct);
            st = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            applyStimulus(1'b1, st, ~d, int'($urandom_range(0, 40)), sv, dr);
            cyc++;
        end
        checkOutput("transfer_timeout", int'(m_phase != 0), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int  cyc;
        bit  dr;
        bit  d;
        int  l;
        resetn    = 1'b0;
        start     = 1'b0;
        dir       = 1'b0;
        len       = '0;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);

        // Idle state straight out of reset.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Single buffer, 8-bit source into 4-bit destination.
        runTransfer(1'b1, 8, 100, 100, 0, 1'b0);
        // Nibble source, three buffers with 8, 8, 4 bytes.
        runTransfer(1'b0, 20, 100, 100, 0, 1'b0);
        // Destination stalled: both buffers fill, then the source must wait.
        runTransfer(1'b1, 24, 100, 100, 40, 1'b0);
        // Zero-length transfer: completion pulse only.
        runTransfer(1'b1, 0, 100, 100, 0, 1'b0);
        // Start pulses while busy must be ignored.
        runTransfer(1'b0, 17, 70, 60, 0, 1'b1);

        // Abort a transfer with reset after 5 bytes, then run a short one.
        applyStimulus(1'b1, 1'b1, 1'b1, 20, 1'b0, 1'b0);
        cyc = 0;
        while (m_wb < 5 && cyc < 200) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
            cyc++;
        end
        checkOutput("abort_progress", int'(m_wb >= 5), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        runTransfer(1'b0, 3, 100, 100, 0, 1'b0);

        // Randomized transfers.
        for (int i = 0; i < 30; i++) begin
            d  = 1'($urandom_range(0, 1));
            l  = int'($urandom_range(0, 40));
            dr = ($urandom_range(0, 3) == 0);
            runTransfer(d, l, int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                        dr ? int'($urandom_range(0, 60)) : 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
